// File: rtl/fm0_enc.sv
// FM0 backscatter encoder: optional pilot, fixed preamble, data bits and dummy-1 trailer,
// advanced on rising edges of doub_blf. Pilot support is built only when FM0_ENC_PILOT_EN is defined.
module fm0_enc (
    input  logic clk_1_92m,
    input  logic rst_n,
    input  logic doub_blf,
    input  logic enc_start,
    input  logic pilot_en,
    input  logic tx_data,
    input  logic tx_valid,
    input  logic tx_last,
    output logic tx_ready,
    output logic enc_out,
    output logic enc_busy,
    output logic enc_done,
    output logic enc_err
);

    typedef enum logic [2:0] {IDLE, PILOT, PREAM, DATA, EOS, DONE} state_t;

    // Element i of the preamble half-symbol sequence sits at bit i.
    localparam logic [11:0] PREAM_PAT = 12'b1100_0100_1011;

    state_t     state_reg, state_next;
    logic [4:0] hcnt_reg, hcnt_next;
    logic       blf_d_reg;
    logic       half_reg, half_next;
    logic       bit_reg, bit_next;
    logic       last_reg, last_next;
    logic       out_reg, out_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic       tick;
    logic       pilot_sel;

    assign tick = doub_blf & ~blf_d_reg;

`ifdef FM0_ENC_PILOT_EN
    assign pilot_sel = pilot_en;
`else
    logic unused_pilot;
    assign unused_pilot = pilot_en;
    assign pilot_sel    = 1'b0;
`endif

    always_ff @(posedge clk_1_92m) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            hcnt_reg  <= '0;
            blf_d_reg <= 1'b0;
            half_reg  <= 1'b0;
            bit_reg   <= 1'b0;
            last_reg  <= 1'b0;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            blf_d_reg <= doub_blf;
            half_reg  <= half_next;
            bit_reg   <= bit_next;
            last_reg  <= last_next;
            out_reg   <= out_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        case (state_reg)
            IDLE: begin
                if (enc_start) begin
                    hcnt_next  = '0;
                    state_next = pilot_sel ? PILOT : PREAM;
                end
            end
`ifdef FM0_ENC_PILOT_EN
            PILOT: begin
                if (tick) begin
                    if (hcnt_reg == 5'd23) begin
                        hcnt_next  = '0;
                        state_next = PREAM;
                    end else begin
                        hcnt_next = hcnt_reg + 5'd1;
                    end
                end
            end
`endif
            PREAM: begin
                if (tick) begin
                    if (hcnt_reg == 5'd11) begin
                        hcnt_next  = '0;
                        state_next = DATA;
                    end else begin
                        hcnt_next = hcnt_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                // Underflow on a first half, or the second half of the last bit, ends the data.
                if (tick && ((!half_reg && !tx_valid) || (half_reg && last_reg))) begin
                    state_next = EOS;
                end
            end
            EOS: begin
                if (tick) begin
                    if (hcnt_reg == 5'd1) begin
                        hcnt_next  = '0;
                        state_next = DONE;
                    end else begin
                        hcnt_next = hcnt_reg + 5'd1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_ready  = (state_reg == DATA) && tick && !half_reg;
        out_next  = out_reg;
        half_next = half_reg;
        bit_next  = bit_reg;
        last_next = last_reg;
        busy_next = busy_reg;
        done_next = 1'b0;
        err_next  = err_reg;
        case (state_reg)
            IDLE: begin
                if (enc_start) begin
                    busy_next = 1'b1;
                    err_next  = 1'b0;
                end
            end
`ifdef FM0_ENC_PILOT_EN
            PILOT: if (tick) out_next = ~hcnt_reg[0];
`endif
            PREAM: if (tick) out_next = PREAM_PAT[hcnt_reg[3:0]];
            DATA: begin
                if (tick) begin
                    if (!half_reg) begin
                        if (tx_valid) begin
                            out_next  = ~out_reg;
                            half_next = 1'b1;
                            bit_next  = tx_data;
                            last_next = tx_last;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        half_next = 1'b0;
                        if (!bit_reg) out_next = ~out_reg;
                    end
                end
            end
            EOS: if (tick && hcnt_reg == 5'd0) out_next = ~out_reg;
            DONE: begin
                out_next  = 1'b0;
                done_next = 1'b1;
                busy_next = 1'b0;
            end
            default: ;
        endcase
    end

    assign enc_out  = out_reg;
    assign enc_busy = busy_reg;
    assign enc_done = done_reg;
    assign enc_err  = err_reg;

endmodule

// File: tb/tb_fm0_enc.sv
// Randomized bench for fm0_enc: each frame's half-symbol sequence is built from FM0 rules
// and compared tick by tick, with random doub_blf timing, start noise, underflow and reset.
module tb_fm0_enc;

    logic clk_1_92m = 1'b0;
    logic rst_n     = 1'b0;
    logic doub_blf  = 1'b0;
    logic enc_start = 1'b0;
    logic pilot_en  = 1'b0;
    logic tx_data   = 1'b0;
    logic tx_valid  = 1'b0;
    logic tx_last   = 1'b0;
    logic tx_ready, enc_out, enc_busy, enc_done, enc_err;

    int   checks   = 0;
    int   failures = 0;
    int   blf_hold = 1;
    bit   blf_fixed = 1'b0;
    logic blf_prev = 1'b0;

`ifdef FM0_ENC_PILOT_EN
    localparam bit PILOT_BUILT = 1'b1;
`else
    localparam bit PILOT_BUILT = 1'b0;
`endif

    typedef struct {
        logic lvl;
        bit   rdy;
        bit   errm;
    } half_t;

    always #5 clk_1_92m = ~clk_1_92m;

    fm0_enc dut (
        .clk_1_92m (clk_1_92m),
        .rst_n     (rst_n),
        .doub_blf  (doub_blf),
        .enc_start (enc_start),
        .pilot_en  (pilot_en),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .enc_out   (enc_out),
        .enc_busy  (enc_busy),
        .enc_done  (enc_done),
        .enc_err   (enc_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // doub_blf waveform: fixed 3-clock half periods, or random 1..3 with occasional 10-clock freezes.
    task automatic next_blf();
        if (blf_hold > 1) begin
            blf_hold--;
        end else begin
            doub_blf = ~doub_blf;
            if (blf_fixed) blf_hold = 3;
            else if ($urandom_range(0, 19) == 0) blf_hold = 10;
            else blf_hold = $urandom_range(1, 3);
        end
    endtask

    task automatic edge_step();
        @(posedge clk_1_92m);
        #1;
        blf_prev = rst_n ? doub_blf : 1'b0;
    endtask

    task automatic run_frame(input bit pil, input int nbits, input logic [15:0] bits,
                             input int err_at, input int rst_at);
        half_t       hq[$];
        logic [0:11] pream;
        logic        lvl, cur, tk;
        bit          err_exp, done_seen;
        int          t, bi, guard;

        pream = 12'b110100100011;
        if (pil && PILOT_BUILT) begin
            for (int i = 0; i < 12; i++) begin
                hq.push_back('{1'b1, 1'b0, 1'b0});
                hq.push_back('{1'b0, 1'b0, 1'b0});
            end
        end
        for (int i = 0; i < 12; i++) hq.push_back('{pream[i], 1'b0, 1'b0});
        lvl = pream[11];
        for (int i = 0; i < nbits; i++) begin
            if (i == err_at) begin
                hq.push_back('{lvl, 1'b1, 1'b1});
                break;
            end
            lvl = ~lvl;
            hq.push_back('{lvl, 1'b1, 1'b0});
            if (!bits[i]) lvl = ~lvl;
            hq.push_back('{lvl, 1'b0, 1'b0});
        end
        lvl = ~lvl;
        hq.push_back('{lvl, 1'b0, 1'b0});
        hq.push_back('{lvl, 1'b0, 1'b0});

        $display("frame pilot=%0d nbits=%0d bits=%0h err_at=%0d rst_at=%0d halves=%0d",
                 pil, nbits, bits, err_at, rst_at, hq.size());

        pilot_en  = pil;
        enc_start = 1'b1;
        next_blf();
        #2;
        check("rdy_idle", tx_ready, 1'b0);
        edge_step();
        enc_start = 1'b0;
        err_exp   = 1'b0;
        cur       = 1'b0;
        check("busy_start", enc_busy, 1'b1);
        check("err_clear", enc_err, 1'b0);
        check("out_start", enc_out, 1'b0);

        t = 0; bi = 0; guard = 0;
        while (t < hq.size() && guard < 3000) begin
            guard++;
            next_blf();
            tx_valid  = (bi < nbits) && (bi != err_at);
            tx_data   = bits[bi[3:0]];
            tx_last   = (bi == nbits - 1);
            enc_start = ($urandom_range(0, 15) == 0);
            #2;
            tk = doub_blf & ~blf_prev;
            check("tx_ready", tx_ready, tk && hq[t].rdy);
            edge_step();
            if (tk) begin
                cur = hq[t].lvl;
                if (hq[t].rdy) bi++;
                if (hq[t].errm) err_exp = 1'b1;
                t++;
            end
            check("enc_out", enc_out, cur);
            check("enc_err", enc_err, err_exp);
            check("busy", enc_busy, 1'b1);
            check("done_early", enc_done, 1'b0);
            if (rst_at >= 0 && t == rst_at) begin
                enc_start = 1'b0;
                rst_n     = 1'b0;
                next_blf();
                edge_step();
                check("rst_out", enc_out, 1'b0);
                check("rst_busy", enc_busy, 1'b0);
                check("rst_done", enc_done, 1'b0);
                check("rst_err", enc_err, 1'b0);
                check("rst_ready", tx_ready, 1'b0);
                rst_n = 1'b1;
                for (int i = 0; i < 40; i++) begin
                    next_blf();
                    #2;
                    check("post_rst_ready", tx_ready, 1'b0);
                    edge_step();
                    check("post_rst_done", enc_done, 1'b0);
                    check("post_rst_out", enc_out, 1'b0);
                    check("post_rst_busy", enc_busy, 1'b0);
                end
                return;
            end
        end
        check("tick_budget", t, hq.size());
        check("bits_taken", bi, (err_at >= 0 && err_at < nbits) ? err_at + 1 : nbits);

        enc_start = 1'b0;
        tx_valid  = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 4 && !done_seen; i++) begin
            next_blf();
            edge_step();
            if (enc_done) done_seen = 1'b1;
        end
        check("done_pulse", done_seen, 1'b1);
        check("out_idle", enc_out, 1'b0);
        check("busy_idle", enc_busy, 1'b0);
        check("err_hold", enc_err, err_exp);
        next_blf();
        edge_step();
        check("done_one_cycle", enc_done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk_1_92m);
        #1;
        check("reset_out", enc_out, 1'b0);
        check("reset_busy", enc_busy, 1'b0);
        check("reset_done", enc_done, 1'b0);
        check("reset_err", enc_err, 1'b0);
        check("reset_ready", tx_ready, 1'b0);
        rst_n = 1'b1;

        blf_fixed = 1'b1;
        run_frame(1'b0, 3, 16'b101, -1, -1);
        run_frame(1'b1, 2, 16'($urandom), -1, -1);
        run_frame(1'b0, 4, 16'($urandom), 0, -1);
        run_frame(1'b0, 5, 16'($urandom), 2, -1);
        run_frame(1'b0, 4, 16'($urandom), -1, 5);
        run_frame(1'b0, 2, 16'b10, -1, -1);

        blf_fixed = 1'b0;
        for (int n = 0; n < 24; n++) begin
            int nb, ea, ra;
            nb = $urandom_range(1, 8);
            ea = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1;
            ra = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 11) : -1;
            run_frame(1'($urandom), nb, 16'($urandom), ea, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fm0_enc.md
FM0_ENC -- requirements
Module: fm0_enc

Interface
REQ-001 SHALL have port clk_1_92m, input, 1 bit: the single 1.92 MHz system clock; all flops are on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port doub_blf, input, 1 bit: double-BLF half-symbol clock from the divider. It is sampled as data and is never used as a clock.
REQ-004 SHALL have port enc_start, input, 1 bit: one-cycle pulse that starts a backscatter frame.
REQ-005 SHALL have port pilot_en, input, 1 bit: TRext; when 1, 12 pilot zeros precede the preamble. It is sampled at enc_start.
REQ-006 SHALL have ports tx_data, tx_valid and tx_last, input, 1 bit each: data bit, bit valid, and final-bit marker.
REQ-007 SHALL have port tx_ready, output, 1 bit: one-cycle pulse; the bit is consumed this cycle if tx_valid=1.
REQ-008 SHALL have port enc_out, output, 1 bit: registered FM0 line level to the modulator.
REQ-009 SHALL have ports enc_busy, enc_done and enc_err, output, 1 bit each: frame in progress; one-cycle end-of-frame pulse; sticky underflow flag.

Function
REQ-010 SHALL register doub_blf into blf_d and generate tick = doub_blf & ~blf_d. All symbol timing advances only on tick.
REQ-011 SHALL update enc_out only in a cycle with tick=1, so enc_out changes exactly 1 clock after the sampled rising edge of doub_blf.
REQ-012 SHALL implement states IDLE, PILOT, PREAM, DATA, EOS and DONE, with a 5-bit half-symbol counter hcnt.
REQ-013 In IDLE, an enc_start pulse SHALL set enc_busy=1 and latch pilot_en. The next state is PILOT if the latched value is 1, otherwise PREAM. hcnt is cleared.
REQ-014 PILOT SHALL emit 12 FM0 zeros (24 ticks) starting from level 0. Each bit inverts the level at its start and again at mid-bit, giving 1,0,1,0,... The state then moves to PREAM.
REQ-015 PREAM SHALL emit the fixed half-symbol pattern 1,1,0,1,0,0,1,0,0,0,1,1 (12 ticks, first element first), independent of the prior level. The state then moves to DATA.
REQ-016 In DATA, on each first-half tick, tx_ready SHALL be 1 for that cycle only. If tx_valid=1, the bit is accepted: the level inverts, and it inverts again on the second-half tick if tx_data=0.
REQ-017 An accepted bit with tx_last=1 SHALL, after its second half, move the state to EOS.
REQ-018 If tx_valid=0 on a DATA first-half tick, the block SHALL set enc_err=1 and go to EOS at that tick without emitting a data half.
REQ-019 EOS SHALL emit the FM0 dummy 1: the level inverts and is held for 2 ticks. The state then moves to DONE.
REQ-020 DONE SHALL, in one cycle, drive enc_out=0, pulse enc_done, clear enc_busy and return to IDLE.
REQ-021 An enc_start pulse while enc_busy=1 SHALL be ignored.
REQ-022 tx_ready SHALL never be asserted outside DATA.
REQ-023 hcnt SHALL wrap only by state-exit clears and never free-run.
REQ-024 enc_err SHALL clear on the next accepted enc_start.

Reset
REQ-025 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear hcnt and blf_d. All outputs go to 0: enc_out, tx_ready, enc_busy, enc_done and enc_err.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no enc_done pulse, and enc_out SHALL be 0 from the next edge.

Configuration
REQ-027 Macro FM0_ENC_PILOT_EN SHALL control pilot support. When defined, the PILOT state and REQ-014 are present. When undefined, the PILOT state is not built, pilot_en is ignored, and every frame starts with PREAM.

Verification
REQ-028 Scenario: doub_blf toggling every 3 clocks, pilot_en=0, bits 1,0,1 with last on the final bit. Required enc_out halves: 110100100011, then 00 10 11, then dummy 00, then enc_done.
REQ-029 Scenario: pilot_en=1 with FM0_ENC_PILOT_EN defined. Required: 24 halves 1010... precede the preamble, and a total of 36 ticks before the first tx_ready.
REQ-030 Scenario: tx_valid held 0 after the preamble. Required: enc_err=1 at the first DATA tick, then 2-tick dummy, then enc_done, with no data halves emitted.
REQ-031 Scenario: enc_start re-pulsed mid-DATA. Required: no effect on the frame, and the bit count is unchanged.
REQ-032 Scenario: rst_n=0 mid-PREAM. Required: IDLE and all outputs 0 at the next edge; no enc_done.
REQ-033 Scenario: doub_blf held constant for 10 clocks mid-frame. Required: enc_out and state frozen, with no tick generated.
